mod_exp_sequencer: RTL and testbench
====================================

Name: mod_exp_sequencer

Overview:
- Handshake-driven sequencer for right-to-left square-and-multiply modular exponentiation on one shared Montgomery multiplier (MMM).
- Unlike a fixed-count schedule, it issues each MMM operation with a start/done handshake and skips work once the remaining exponent bits are zero.
- A watchdog aborts the run if the MMM stalls.
- Sits between the host register interface (start/exp_e) and the MMM datapath operand muxes and result registers A and R.

Parameters:
- EXP_W, 8, exponent width in bits.
- TIMEOUT, 255, maximum en-cycles waited for mmm_done after an mmm_start.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable, shared with the MMM.
- start  in  1  request exponentiation; sampled in IDLE only.
- abort  in  1  cancel the current run.
- exp_e  in  EXP_W  exponent; captured on start acceptance.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse: result valid in R.
- err  out  1  one-cycle pulse: watchdog expired.
- init_r  out  1  one-cycle pulse: load R with the Montgomery-one constant.
- mmm_start  out  1  one-cycle pulse: MMM samples operands.
- mmm_op  out  2  operand select: 00 PRE (M·R²→A), 01 MUL (R·A→R), 10 SQR (A·A→A), 11 FIN (R·1→R).
- mmm_done  in  1  one-cycle pulse from the MMM.
- ld_a  out  1  one-cycle pulse: load MMM result into A.
- ld_r  out  1  one-cycle pulse: load MMM result into R.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clock edge) values: state=IDLE, every output 0, exponent register 0, watchdog counter 0. rst has the highest priority.
- en=0: state, exponent register, counter and all outputs hold. Pulse outputs are ANDed with en, so a pending pulse appears on the first en=1 cycle. mmm_done is sampled only when en=1.
- abort=1 (any en value): next state IDLE, all outputs 0, no done and no err.
- Priority: rst > abort > all else. start and abort together in IDLE leave the block IDLE.

States: IDLE, ISSUE, WAIT, LOAD, FINISH.
- IDLE:
  - start=1 and en=1 at cycle T → e_reg <= exp_e; op <= PRE.
  - Cycle T+1: busy=1, init_r=1, mmm_start=1, mmm_op=00.
  - start is ignored while busy.
- ISSUE: one cycle; mmm_start=1 with mmm_op=op, watchdog cleared; go to WAIT.
- WAIT:
  - mmm_done=1 at cycle D → LOAD.
  - The watchdog increments each en cycle; mmm_done on the cycle the count equals TIMEOUT is still accepted.
  - Count reaching TIMEOUT with no mmm_done → err=1 next cycle, busy=0, IDLE.
  - mmm_op holds its value throughout WAIT.
- LOAD (cycle D+1): pulse ld_a for PRE/SQR, or ld_r for MUL/FIN. Next op is chosen as follows:
  - PRE: e_reg==0 → FIN; e_reg[0]=1 → MUL; else SQR.
  - MUL: e_reg[EXP_W-1:1]==0 → FIN; else SQR.
  - SQR: e_reg <= e_reg>>1; next = MUL if shifted bit0=1, else SQR. The shifted value is nonzero by construction.
  - FIN: → FINISH.
- Non-FIN ops: ISSUE at D+2, so there is no MMM start in the same cycle as a result load.
- FINISH (cycle D+2 after FIN): done=1, busy=0, mmm_op=00; return to IDLE.
- Operation count = 2 + popcount(e) + (index of MSB set), for e≠0. e=0 gives 2 ops and a result of Montgomery-converted 1, i.e. x^0=1.
- A new start is accepted on the cycle after done.

Test Plan:
- MMM model returns mmm_done 1 cycle after mmm_start; exp_e=0; start at T → mmm_start at T+1 (op 00, init_r=1), ld_a T+3, mmm_start T+4 (op 11), ld_r T+6, done T+7 with busy=0.
- exp_e=8'b0000_0101 → mmm_op sequence 00,01,10,10,01,11; ld pulses a,r,a,a,r,r; exactly 6 mmm_start pulses; then done.
- exp_e=8'hFF → 17 ops: PRE, then 8 MUL interleaved with 7 SQR, then FIN; no SQR after the last MUL.
- MMM never responds, TIMEOUT=255 → err pulse exactly 256 en-cycles after mmm_start, busy=0, no done; mmm_done at count 255 instead → accepted, no err.
- en toggled low for 3 cycles during ISSUE and WAIT → all outputs frozen, pending mmm_start/ld pulses delayed 3 cycles, op sequence unchanged.
- abort during WAIT of the 2nd op → IDLE next cycle, outputs 0, no done; abort+start together in IDLE → stays IDLE; rst mid-run → all outputs 0 next cycle.

Source files
------------

// File: rtl/mod_exp_sequencer.sv
// Handshake-driven right-to-left square-and-multiply sequencer for one shared
// Montgomery multiplier, with early exit on exhausted exponent and an MMM watchdog.
module mod_exp_sequencer #(
    parameter int EXP_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             abort,
    input  logic [EXP_W-1:0] exp_e,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             init_r,
    output logic             mmm_start,
    output logic [1:0]       mmm_op,
    input  logic             mmm_done,
    output logic             ld_a,
    output logic             ld_r
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, LOAD, FINISH} state_t;
    typedef enum logic [1:0] {OP_PRE = 2'b00, OP_MUL = 2'b01, OP_SQR = 2'b10, OP_FIN = 2'b11} op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [EXP_W-1:0]   e_q, e_d, e_shift;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               init_q, init_d;
    logic               start_q, start_d;
    logic               ld_a_q, ld_a_d;
    logic               ld_r_q, ld_r_d;

    assign e_shift = e_q >> 1;

    always_comb begin
        // NOTE: every next-state value starts from its held copy so no path leaves
        // a variable unassigned; that is what keeps this block free of latches.
        state_d = state_q;
        op_d    = op_q;
        e_d     = e_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        init_d  = init_q;
        start_d = start_q;
        ld_a_d  = ld_a_q;
        ld_r_d  = ld_r_q;

        if (abort) begin
            state_d = IDLE;
            op_d    = OP_PRE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            init_d  = 1'b0;
            start_d = 1'b0;
            ld_a_d  = 1'b0;
            ld_r_d  = 1'b0;
        end else if (en) begin
            // Pulses last one enabled cycle; with en low they stay pending above.
            done_d  = 1'b0;
            err_d   = 1'b0;
            init_d  = 1'b0;
            start_d = 1'b0;
            ld_a_d  = 1'b0;
            ld_r_d  = 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ISSUE;
                        e_d     = exp_e;
                        op_d    = OP_PRE;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        init_d  = 1'b1;
                        start_d = 1'b1;
                    end
                end
                ISSUE: begin
                    // The mmm_start cycle itself is the first watched cycle.
                    state_d = WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end
                WAIT: begin
                    if (mmm_done) begin
                        state_d = LOAD;
                        ld_a_d  = (op_q == OP_PRE) || (op_q == OP_SQR);
                        ld_r_d  = (op_q == OP_MUL) || (op_q == OP_FIN);
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        state_d = IDLE;
                        op_d    = OP_PRE;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                LOAD: begin
                    if (op_q == OP_FIN) begin
                        state_d = FINISH;
                        op_d    = OP_PRE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        start_d = 1'b1;
                        cnt_d   = '0;
                        case (op_q)
                            OP_PRE:  op_d = (e_q == '0) ? OP_FIN : (e_q[0] ? OP_MUL : OP_SQR);
                            OP_MUL:  op_d = (e_shift == '0) ? OP_FIN : OP_SQR;
                            default: begin
                                // SQR consumes one exponent bit; remainder is nonzero here.
                                e_d  = e_shift;
                                op_d = e_shift[0] ? OP_MUL : OP_SQR;
                            end
                        endcase
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_PRE;
            e_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
            start_q <= 1'b0;
            ld_a_q  <= 1'b0;
            ld_r_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            e_q     <= e_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            init_q  <= init_d;
            start_q <= start_d;
            ld_a_q  <= ld_a_d;
            ld_r_q  <= ld_r_d;
        end
    end

    assign busy      = busy_q;
    assign mmm_op    = op_q;
    assign done      = done_q  & en;
    assign err       = err_q   & en;
    assign init_r    = init_q  & en;
    assign mmm_start = start_q & en;
    assign ld_a      = ld_a_q  & en;
    assign ld_r      = ld_r_q  & en;

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Directed bench for mod_exp_sequencer: cycle-exact e=0 run, op traces, watchdog,
// enable freezing, abort and reset behaviour against a 1-cycle MMM responder.
module tb_mod_exp_sequencer;

    logic       clk = 1'b0;
    logic       rst, en, start, abort, mmm_done;
    logic [7:0] exp_e;
    logic       busy, done, err, init_r, mmm_start, ld_a, ld_r;
    logic [1:0] mmm_op;

    logic       mmm_auto;
    int         checks = 0;
    int         errors = 0;

    logic [1:0] op_log[$];
    logic [31:0] ld_pack;
    int         n_ld;
    logic       first_start, done_seen, err_seen;

    always #5 clk = ~clk;

    mod_exp_sequencer #(.EXP_W(8), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort), .exp_e(exp_e),
        .busy(busy), .done(done), .err(err), .init_r(init_r), .mmm_start(mmm_start),
        .mmm_op(mmm_op), .mmm_done(mmm_done), .ld_a(ld_a), .ld_r(ld_r)
    );

    function automatic logic [8:0] outs();
        return {busy, done, err, init_r, mmm_start, mmm_op, ld_a, ld_r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the MMM answers one enabled cycle after mmm_start and
    // freezes with the shared enable.
    task automatic tick();
        logic s, e;
        s = mmm_start;
        e = en;
        @(posedge clk);
        #1;
        if (e) mmm_done = mmm_auto & s;
    endtask

    task automatic drive(input logic i_en, input logic i_start, input logic i_abort,
                         input logic [7:0] i_exp);
        en    = i_en;
        start = i_start;
        abort = i_abort;
        exp_e = i_exp;
        #1;
    endtask

    task automatic run_trace(input logic [7:0] e, input int budget);
        op_log.delete();
        ld_pack   = '0;
        n_ld      = 0;
        done_seen = 1'b0;
        err_seen  = 1'b0;
        drive(1'b1, 1'b1, 1'b0, e);
        tick();
        drive(1'b1, 1'b0, 1'b0, e);
        first_start = mmm_start;
        for (int c = 0; c < budget && !done_seen; c++) begin
            if (mmm_start) op_log.push_back(mmm_op);
            if (ld_a | ld_r) begin
                ld_pack = (ld_pack << 1) | {31'b0, ld_r};
                n_ld++;
            end
            if (err) err_seen = 1'b1;
            if (done) done_seen = 1'b1;
            else tick();
        end
    endtask

    initial begin
        logic [31:0] pack;
        int          bad;
        logic        seen;

        rst = 1'b1; en = 1'b1; start = 1'b0; abort = 1'b0; exp_e = '0;
        mmm_done = 1'b0; mmm_auto = 1'b1;
        tick(); tick();
        check("reset_outs", outs(), 0);
        rst = 1'b0;
        tick();

        // e = 0: cycle-exact schedule
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("e0_idle_busy", busy, 0);
        tick(); drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("e0_t1_pre", {busy, init_r, mmm_start, mmm_op}, 5'b11100);
        tick(); check("e0_t2_wait", outs(), 9'h100);
        tick(); check("e0_t3_ld_a", {ld_a, ld_r}, 2'b10);
        tick(); check("e0_t4_fin", {mmm_start, mmm_op, init_r}, 4'b1110);
        tick(); tick(); check("e0_t6_ld_r", {ld_a, ld_r}, 2'b01);
        tick(); check("e0_t7_done", {done, busy, mmm_op}, 4'b1000);
        tick(); check("e0_t8_idle", outs(), 0);

        // e = 5, started on the cycle right after done
        run_trace(8'h05, 100);
        check("e5_first_start", first_start, 1);
        check("e5_done", done_seen, 1);
        check("e5_busy_at_done", busy, 0);
        check("e5_op_count", op_log.size(), 6);
        pack = '0;
        foreach (op_log[i]) pack = (pack << 2) | {30'b0, op_log[i]};
        check("e5_op_seq", pack, 32'h1A7);
        check("e5_ld_seq", ld_pack, 32'h13);
        check("e5_ld_count", n_ld, 6);

        // e = 0xFF: PRE, MUL/SQR alternating, FIN
        tick();
        run_trace(8'hFF, 200);
        check("ff_done", done_seen, 1);
        check("ff_op_count", op_log.size(), 17);
        bad = 0;
        foreach (op_log[i]) begin
            if (i == 0)               bad += (op_log[i] != 2'b00) ? 1 : 0;
            else if (i == 16)         bad += (op_log[i] != 2'b11) ? 1 : 0;
            else if (i % 2 == 1)      bad += (op_log[i] != 2'b01) ? 1 : 0;
            else                      bad += (op_log[i] != 2'b10) ? 1 : 0;
        end
        check("ff_op_seq", bad, 0);
        check("ff_ld_count", n_ld, 17);
        check("ff_no_err", err_seen, 0);

        // Watchdog expiry: MMM silent
        tick();
        mmm_auto = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        tick(); drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("to_start", mmm_start, 1);
        seen = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            seen |= err;
        end
        check("to_no_early_err", seen, 0);
        check("to_busy_255", busy, 1);
        tick();
        check("to_err_256", {err, busy, done}, 3'b100);
        tick();
        check("to_err_pulse_end", {err, busy}, 2'b00);

        // mmm_done exactly at count 255 is accepted
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        tick(); drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= 255; k++) tick();
        mmm_done = 1'b1;
        #1;
        tick();
        check("to255_accept", {ld_a, err, busy}, 3'b101);
        tick();
        check("to255_fin_issue", {mmm_start, mmm_op}, 3'b111);
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        tick(); drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("abort_issue_outs", outs(), 0);
        mmm_auto = 1'b1;

        // en low 3 cycles in ISSUE and 3 in WAIT
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        tick(); drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("en_issue_frozen", {busy, init_r, mmm_start, mmm_op}, 5'b10000);
        tick(); check("en_issue_frozen2", outs(), 9'h100);
        tick(); tick(); drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("en_start_delayed", {busy, init_r, mmm_start, mmm_op}, 5'b11100);
        tick(); drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("en_wait_frozen", outs(), 9'h100);
        tick(); tick(); tick(); drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("en_wait_no_ld", ld_a, 0);
        tick(); check("en_ld_a_delayed", {ld_a, ld_r}, 2'b10);
        tick(); check("en_fin_issue", {mmm_start, mmm_op}, 3'b111);
        tick(); tick(); check("en_ld_r", ld_r, 1);
        tick(); check("en_done", {done, busy}, 2'b10);

        // abort during WAIT of the second op (MUL)
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h05);
        tick(); drive(1'b1, 1'b0, 1'b0, 8'h05);
        tick(); tick(); tick();
        check("ab_mul_issue", {mmm_start, mmm_op}, 3'b101);
        tick(); drive(1'b1, 1'b0, 1'b1, 8'h05);
        tick(); drive(1'b1, 1'b0, 1'b0, 8'h05);
        check("ab_outs_zero", outs(), 0);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen |= done | busy | mmm_start;
        end
        check("ab_stays_idle", seen, 0);

        // start and abort together in IDLE
        drive(1'b1, 1'b1, 1'b1, 8'h05);
        tick(); drive(1'b1, 1'b0, 1'b0, 8'h05);
        check("ab_start_idle", outs(), 0);
        tick(); check("ab_start_idle2", busy, 0);

        // reset mid-run
        drive(1'b1, 1'b1, 1'b0, 8'hFF);
        tick(); drive(1'b1, 1'b0, 1'b0, 8'hFF);
        tick(); tick(); tick(); tick();
        check("rst_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        check("rst_outs_zero", outs(), 0);
        rst = 1'b0;
        tick();
        check("rst_idle_after", outs(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
